apb_slave_mem: RTL

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave fronting a byte-wide storage array.
// Transfers go IDLE -> (WAIT) -> READY. Address, direction and write data are
// captured at the setup edge. Reads load prdata on the edge entering READY.
// Writes commit only at the completing edge.
// Optional build macro APB_SLV_PSLVERR_EN: addresses >= MEM_DEPTH answer with
// pslverr=1, suppress the write and return 8'h00 on reads. Without the macro,
// pslverr is tied low and the address wraps modulo MEM_DEPTH.
module apb_slave_mem #(
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic       prot_err
);

    localparam int         AW      = $clog2(MEM_DEPTH);
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic          r_write;
    logic [7:0]    r_wdata;
    logic [7:0]    r_prdata;
    logic          r_prot_err;
    logic [7:0]    r_mem [MEM_DEPTH];

    logic          w_setup;
    logic          w_complete;
    logic          w_violation;
    logic          w_dec;
    logic          w_enter_ready;
    logic [AW-1:0] w_rd_idx;
    logic          w_rd_write;
    logic          w_rd_err;
    logic          w_wr_commit;
    logic          w_unused_addr;

    // Address bits above the index only matter for the range check.
    assign w_unused_addr = ^(paddr >> AW);

    // State register; reset forces IDLE and drops any transfer in flight.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the setup / completion / violation strobes.
    always_comb begin
        w_next_state = r_state;
        w_setup      = 1'b0;
        w_complete   = 1'b0;
        w_violation  = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            IDLE: begin
                if (psel && !penable) begin
                    w_setup = 1'b1;
                end else if (psel && penable) begin
                    // access phase with no setup: ignore it, flag it
                    w_violation = 1'b1;
                end
            end
            WAIT: begin
                if (!psel) begin
                    w_next_state = IDLE;
                    w_violation  = 1'b1;
                end else if (!penable) begin
                    // master restarted: the old transfer is dropped
                    w_setup     = 1'b1;
                    w_violation = 1'b1;
                end else begin
                    w_dec = 1'b1;
                    // <= covers a zero count so the FSM can never stick here
                    if (r_cnt <= 4'd1) begin
                        w_next_state = READY;
                    end
                end
            end
            READY: begin
                if (!psel) begin
                    w_next_state = IDLE;
                    w_violation  = 1'b1;
                end else if (!penable) begin
                    w_setup     = 1'b1;
                    w_violation = 1'b1;
                end else begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (w_setup) begin
            w_next_state = (LP_WAIT == 4'd0) ? READY : WAIT;
        end
    end

    // READY never holds itself without a fresh setup, so arriving there is a
    // plain state compare.
    assign w_enter_ready = (w_next_state == READY);

    // With zero wait cycles READY follows the setup edge directly, so the read
    // has to use the live bus instead of the captured copy.
    assign w_rd_idx   = w_setup ? paddr[AW-1:0] : r_addr;
    assign w_rd_write = w_setup ? pwrite : r_write;

`ifdef APB_SLV_PSLVERR_EN
    logic [8:0] w_depth;
    logic       w_addr_oor;
    logic       r_err;

    assign w_depth    = 9'(MEM_DEPTH);
    assign w_addr_oor = ({1'b0, paddr} >= w_depth);
    assign w_rd_err   = w_setup ? w_addr_oor : r_err;

    // Range-error flag captured with the address at setup.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_err <= 1'b0;
        end else if (w_setup) begin
            r_err <= w_addr_oor;
        end
    end

    assign pslverr = (r_state == READY) && r_err;
`else
    assign w_rd_err = 1'b0;
    assign pslverr  = 1'b0;
`endif

    // A write lands only on the completing edge of an in-range transfer.
    assign w_wr_commit = w_complete && r_write && !w_rd_err;

    // Wait counter: loaded at setup, counts down through WAIT.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_cnt <= 4'd0;
        end else if (w_setup) begin
            r_cnt <= LP_WAIT;
        end else if (w_dec) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Setup capture; later changes on the bus are ignored until the next setup.
    always_ff @(posedge pclk) begin
        if (w_setup) begin
            r_addr  <= paddr[AW-1:0];
            r_write <= pwrite;
            r_wdata <= pwdata;
        end
    end

    // Read data register: updated only when a read arrives in READY.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_prdata <= 8'h00;
        end else if (w_enter_ready && !w_rd_write) begin
            r_prdata <= w_rd_err ? 8'h00 : r_mem[w_rd_idx];
        end
    end

    // Storage array: reset clears every location.
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_wr_commit) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // Protocol-violation pulse, one cycle after the offending edge.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_prot_err <= 1'b0;
        end else begin
            r_prot_err <= w_violation;
        end
    end

    assign pready   = (r_state == READY);
    assign prdata   = r_prdata;
    assign prot_err = r_prot_err;

endmodule
